// File: rtl/age_ordered_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : age_ordered_rs_pkg
// Description : Shared types and default sizing for the age-ordered
//               reservation station (flush bundle, CDB channel, age helper).
// Revision    : 1.0 - initial release
// ============================================================================
package age_ordered_rs_pkg;

   // Default configuration; the structs below are sized for it.
   localparam int unsigned RS_DEPTH     = 8;
   localparam int unsigned RS_ROB_DEPTH = 16;
   localparam int unsigned RS_TAG_W     = $clog2(RS_ROB_DEPTH);
   localparam int unsigned RS_NUM_CDB   = 2;
   localparam int unsigned RS_XLEN      = 32;
   localparam int unsigned RS_OP_W      = 8;

   // Partial flush request: kill everything at or younger than tag.
   typedef struct packed {
      logic                valid;
      logic [RS_TAG_W-1:0] tag;
   } rs_flush_t;

   // One common-data-bus result channel.
   typedef struct packed {
      logic                valid;
      logic [RS_TAG_W-1:0] tag;
      logic [RS_XLEN-1:0]  data;
   } cdb_t;

   // Age of a ROB tag relative to the ROB head; wraps modulo ROB depth.
   function automatic logic [RS_TAG_W-1:0] rob_age(
      input logic [RS_TAG_W-1:0] tag,
      input logic [RS_TAG_W-1:0] head
   );
      return tag - head;
   endfunction

endpackage
`default_nettype wire

// File: rtl/age_ordered_rs_if.sv
`default_nettype none
// ============================================================================
// Module      : age_ordered_rs_if
// Description : Dispatch / wakeup / flush / issue bundle of the reservation
//               station. master = surrounding pipeline, slave = the RS.
// Revision    : 1.0 - initial release
// ============================================================================
interface age_ordered_rs_if
   import age_ordered_rs_pkg::*;
#(
   parameter int unsigned DEPTH   = RS_DEPTH,
   parameter int unsigned TAG_W   = RS_TAG_W,
   parameter int unsigned NUM_CDB = RS_NUM_CDB,
   parameter int unsigned XLEN    = RS_XLEN,
   parameter int unsigned OP_W    = RS_OP_W
);
   // flush and age reference
   logic                     flush_valid;
   logic [TAG_W-1:0]         flush_tag;
   logic [TAG_W-1:0]         rob_head;
   // dispatch
   logic                     disp_valid;
   logic                     disp_ready;
   logic [TAG_W-1:0]         disp_tag;
   logic [OP_W-1:0]          disp_op;
   logic                     disp_busy1;
   logic                     disp_busy2;
   logic [XLEN-1:0]          disp_src1;
   logic [XLEN-1:0]          disp_src2;
   // common data bus
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*TAG_W-1:0] cdb_tag;
   logic [NUM_CDB*XLEN-1:0]  cdb_data;
   // issue
   logic                     iss_valid;
   logic                     iss_ready;
   logic [TAG_W-1:0]         iss_tag;
   logic [OP_W-1:0]          iss_op;
   logic [XLEN-1:0]          iss_src1;
   logic [XLEN-1:0]          iss_src2;
   // occupancy
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output flush_valid, flush_tag, rob_head,
      output disp_valid, disp_tag, disp_op, disp_busy1, disp_busy2,
      output disp_src1, disp_src2,
      output cdb_valid, cdb_tag, cdb_data,
      output iss_ready,
      input  disp_ready, iss_valid, iss_tag, iss_op, iss_src1, iss_src2,
      input  count
   );

   modport slave (
      input  flush_valid, flush_tag, rob_head,
      input  disp_valid, disp_tag, disp_op, disp_busy1, disp_busy2,
      input  disp_src1, disp_src2,
      input  cdb_valid, cdb_tag, cdb_data,
      input  iss_ready,
      output disp_ready, iss_valid, iss_tag, iss_op, iss_src1, iss_src2,
      output count
   );
endinterface
`default_nettype wire

// File: rtl/age_ordered_rs_select.sv
`default_nettype none
// ============================================================================
// Module      : age_ordered_rs_select
// Description : Oldest-ready select. Binary compare tree over the ready
//               vector and per-entry ages; yields one-hot grant and index.
// Revision    : 1.0 - initial release
// ============================================================================
module age_ordered_rs_select #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AGE_W = 4
) (
   input  logic [DEPTH-1:0]         ready_i,
   input  logic [AGE_W-1:0]         age_i [DEPTH],
   output logic [DEPTH-1:0]         grant_o,
   output logic [$clog2(DEPTH)-1:0] idx_o,
   output logic                     any_o
);
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned LEAVES = 1 << IDX_W;
   localparam int unsigned NODES  = 2 * LEAVES - 1;

   logic             w_node_v   [NODES];
   logic [AGE_W-1:0] w_node_age [NODES];
   logic [IDX_W-1:0] w_node_idx [NODES];

   // Heap-ordered tree: leaves at LEAVES-1.., each parent keeps the younger-age
   // (older op) child. Padding leaves never win.
   always_comb begin
      for (int n = 0; n < NODES; n++) begin
         w_node_v[n]   = 1'b0;
         w_node_age[n] = '0;
         w_node_idx[n] = '0;
      end
      for (int i = 0; i < LEAVES; i++) begin
         if (i < DEPTH) begin
            w_node_v[LEAVES-1+i]   = ready_i[i];
            w_node_age[LEAVES-1+i] = age_i[i];
            w_node_idx[LEAVES-1+i] = IDX_W'(i);
         end
      end
      for (int n = LEAVES - 2; n >= 0; n--) begin
         if (w_node_v[2*n+1] &&
             (!w_node_v[2*n+2] || (w_node_age[2*n+1] < w_node_age[2*n+2]))) begin
            w_node_v[n]   = 1'b1;
            w_node_age[n] = w_node_age[2*n+1];
            w_node_idx[n] = w_node_idx[2*n+1];
         end else begin
            w_node_v[n]   = w_node_v[2*n+2];
            w_node_age[n] = w_node_age[2*n+2];
            w_node_idx[n] = w_node_idx[2*n+2];
         end
      end
   end

   assign any_o = w_node_v[0];
   assign idx_o = w_node_idx[0];

   // Expand the winning index into a one-hot grant.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         grant_o[i] = w_node_v[0] && (w_node_idx[0] == IDX_W'(i));
      end
   end

endmodule
`default_nettype wire

// File: rtl/age_ordered_rs.sv
`default_nettype none
// ============================================================================
// Module      : age_ordered_rs
// Description : Parametrised reservation station. Holds dispatched ops until
//               both operands resolve via CDB wakeup, issues the oldest ready
//               entry (ROB age) over valid/ready, supports age-based flush.
// Revision    : 1.0 - initial release
// ============================================================================
module age_ordered_rs
   import age_ordered_rs_pkg::*;
#(
   parameter int unsigned DEPTH     = RS_DEPTH,
   parameter int unsigned ROB_DEPTH = RS_ROB_DEPTH,
   parameter int unsigned NUM_CDB   = RS_NUM_CDB,
   parameter int unsigned XLEN      = RS_XLEN,
   parameter int unsigned OP_W      = RS_OP_W
) (
   input  logic            clk,
   input  logic            rst,
   age_ordered_rs_if.slave rs
);
   localparam int unsigned TAG_W = $clog2(ROB_DEPTH);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE_COUNT  = CNT_W'(1);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [OP_W-1:0]  op;
      logic             busy1;
      logic [XLEN-1:0]  src1;
      logic             busy2;
      logic [XLEN-1:0]  src2;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   rs_flush_t        w_flush;
   cdb_t             w_cdb [NUM_CDB];
   logic [DEPTH-1:0] w_ready;
   logic [TAG_W-1:0] w_age [DEPTH];
   logic [DEPTH-1:0] w_grant;
   logic [IDX_W-1:0] w_sel_idx;
   logic             w_sel_any;
   logic [IDX_W-1:0] w_free_idx;
   logic             w_free_found;
   logic             w_issue_fire;
   logic             w_disp_fire;
   logic [TAG_W-1:0] w_flush_age;
   entry_t           w_new_entry;

   assign w_flush.valid = rs.flush_valid;
   assign w_flush.tag   = rs.flush_tag;

   for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
      assign w_cdb[c].valid = rs.cdb_valid[c];
      assign w_cdb[c].tag   = rs.cdb_tag[c*TAG_W +: TAG_W];
      assign w_cdb[c].data  = rs.cdb_data[c*XLEN +: XLEN];
   end

   // Readiness and age from registered state only: no CDB-to-issue bypass.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_ready[i] = ent_q[i].valid & ~ent_q[i].busy1 & ~ent_q[i].busy2;
         w_age[i]   = rob_age(ent_q[i].tag, rs.rob_head);
      end
   end

   age_ordered_rs_select #(
      .DEPTH (DEPTH),
      .AGE_W (TAG_W)
   ) u_select (
      .ready_i (w_ready),
      .age_i   (w_age),
      .grant_o (w_grant),
      .idx_o   (w_sel_idx),
      .any_o   (w_sel_any)
   );

   // Flush and reset both suppress the issue presented this cycle.
   assign rs.iss_valid  = w_sel_any & ~w_flush.valid & ~rst;
   assign rs.iss_tag    = ent_q[w_sel_idx].tag;
   assign rs.iss_op     = ent_q[w_sel_idx].op;
   assign rs.iss_src1   = ent_q[w_sel_idx].src1;
   assign rs.iss_src2   = ent_q[w_sel_idx].src2;
   assign rs.disp_ready = (count_q < FULL_COUNT);
   assign rs.count      = count_q;

   assign w_issue_fire = rs.iss_valid & rs.iss_ready;
   assign w_disp_fire  = rs.disp_valid & rs.disp_ready & ~w_flush.valid;
   assign w_flush_age  = rob_age(w_flush.tag, rs.rob_head);

   // Lowest-index free entry receives the next dispatch.
   always_comb begin
      w_free_idx   = '0;
      w_free_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!ent_q[i].valid && !w_free_found) begin
            w_free_idx   = IDX_W'(i);
            w_free_found = 1'b1;
         end
      end
   end

   // Build the incoming entry, forwarding a same-cycle CDB result into busy
   // sources. Channels scanned high to low so the lowest index wins.
   always_comb begin
      w_new_entry.valid = 1'b1;
      w_new_entry.tag   = rs.disp_tag;
      w_new_entry.op    = rs.disp_op;
      w_new_entry.busy1 = rs.disp_busy1;
      w_new_entry.src1  = rs.disp_src1;
      w_new_entry.busy2 = rs.disp_busy2;
      w_new_entry.src2  = rs.disp_src2;
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
         if (w_cdb[c].valid) begin
            if (rs.disp_busy1 && (rs.disp_src1[TAG_W-1:0] == w_cdb[c].tag)) begin
               w_new_entry.busy1 = 1'b0;
               w_new_entry.src1  = w_cdb[c].data;
            end
            if (rs.disp_busy2 && (rs.disp_src2[TAG_W-1:0] == w_cdb[c].tag)) begin
               w_new_entry.busy2 = 1'b0;
               w_new_entry.src2  = w_cdb[c].data;
            end
         end
      end
   end

   // Next entry state: wakeup, issue free, dispatch write, then flush kill.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].valid) begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
               if (w_cdb[c].valid) begin
                  if (ent_q[i].busy1 && (ent_q[i].src1[TAG_W-1:0] == w_cdb[c].tag)) begin
                     ent_d[i].busy1 = 1'b0;
                     ent_d[i].src1  = w_cdb[c].data;
                  end
                  if (ent_q[i].busy2 && (ent_q[i].src2[TAG_W-1:0] == w_cdb[c].tag)) begin
                     ent_d[i].busy2 = 1'b0;
                     ent_d[i].src2  = w_cdb[c].data;
                  end
               end
            end
         end
         if (w_issue_fire && w_grant[i]) begin
            ent_d[i].valid = 1'b0;
         end
      end
      if (w_disp_fire) begin
         ent_d[w_free_idx] = w_new_entry;
      end
      if (w_flush.valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rob_age(ent_d[i].tag, rs.rob_head) >= w_flush_age) begin
               ent_d[i].valid = 1'b0;
            end
         end
      end
   end

   // Occupancy: incremental normally, popcount of survivors after a flush.
   always_comb begin
      count_d = count_q;
      if (w_flush.valid) begin
         count_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{(CNT_W-1){1'b0}}, ent_d[i].valid};
         end
      end else if (w_disp_fire && !w_issue_fire) begin
         count_d = count_q + ONE_COUNT;
      end else if (!w_disp_fire && w_issue_fire) begin
         count_d = count_q - ONE_COUNT;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_age_ordered_rs.sv
`default_nettype none
// ============================================================================
// Module      : tb_age_ordered_rs
// Description : Self-checking bench for age_ordered_rs with an issue
//               scoreboard and direct state checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_age_ordered_rs;

   logic clk;
   logic rst;

   age_ordered_rs_if #(
      .DEPTH(8), .TAG_W(4), .NUM_CDB(2), .XLEN(32), .OP_W(8)
   ) bus ();

   age_ordered_rs #(
      .DEPTH(8), .ROB_DEPTH(16), .NUM_CDB(2), .XLEN(32), .OP_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rs  (bus)
   );

   typedef struct {
      logic [3:0]  tag;
      logic [7:0]  op;
      logic [31:0] s1;
      logic [31:0] s2;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.disp_valid  = 1'b0;
      bus.disp_tag    = '0;
      bus.disp_op     = '0;
      bus.disp_busy1  = 1'b0;
      bus.disp_busy2  = 1'b0;
      bus.disp_src1   = '0;
      bus.disp_src2   = '0;
      bus.cdb_valid   = '0;
      bus.cdb_tag     = '0;
      bus.cdb_data    = '0;
      bus.flush_valid = 1'b0;
      bus.flush_tag   = '0;
   endtask

   task automatic disp(input logic [3:0] tag, input logic [7:0] op,
                       input logic b1, input logic [31:0] s1,
                       input logic b2, input logic [31:0] s2);
      bus.disp_valid = 1'b1;
      bus.disp_tag   = tag;
      bus.disp_op    = op;
      bus.disp_busy1 = b1;
      bus.disp_src1  = s1;
      bus.disp_busy2 = b2;
      bus.disp_src2  = s2;
   endtask

   task automatic cdb(input int ch, input logic [3:0] tag, input logic [31:0] data);
      bus.cdb_valid[ch]          = 1'b1;
      bus.cdb_tag[ch*4 +: 4]     = tag;
      bus.cdb_data[ch*32 +: 32]  = data;
   endtask

   task automatic push(input logic [3:0] tag, input logic [7:0] op,
                       input logic [31:0] s1, input logic [31:0] s2);
      exp_t e;
      e.tag = tag; e.op = op; e.s1 = s1; e.s2 = s2;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      bus.iss_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (sb.size() == 0) break;
         tick();
      end
      check_val(name, 32'(sb.size()), 32'd0);
   endtask

   // Scoreboard: every accepted issue must match the oldest pending expectation.
   always @(negedge clk) begin
      if (bus.iss_valid === 1'b1 && bus.iss_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("unexpected_issue_tag", 32'(bus.iss_tag), 32'hDEAD);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val("iss_tag",  32'(bus.iss_tag), 32'(e.tag));
            check_val("iss_op",   32'(bus.iss_op),  32'(e.op));
            check_val("iss_src1", bus.iss_src1, e.s1);
            check_val("iss_src2", bus.iss_src2, e.s2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle();
      bus.rob_head  = '0;
      bus.iss_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_count",      32'(bus.count),      32'd0);
      check_val("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
      check_val("rst_iss_valid",  32'(bus.iss_valid),  32'd0);
      tick();

      // 1: ready dispatch issues the following cycle
      disp(4'd3, 8'h11, 1'b0, 32'd5, 1'b0, 32'd7);
      push(4'd3, 8'h11, 32'd5, 32'd7);
      @(negedge clk);
      check_val("t1_no_issue_same_cycle", 32'(bus.iss_valid), 32'd0);
      tick(); idle();
      @(negedge clk);
      check_val("t1_iss_valid", 32'(bus.iss_valid), 32'd1);
      tick();
      @(negedge clk);
      check_val("t1_count_after", 32'(bus.count), 32'd0);
      tick();

      // 2: wakeup from CDB one cycle after dispatch
      disp(4'd4, 8'h22, 1'b1, 32'd2, 1'b0, 32'd8);
      tick(); idle();
      cdb(0, 4'd2, 32'h99);
      push(4'd4, 8'h22, 32'h99, 32'd8);
      @(negedge clk);
      check_val("t2_not_ready_at_wakeup", 32'(bus.iss_valid), 32'd0);
      tick(); idle();
      @(negedge clk);
      check_val("t2_iss_valid", 32'(bus.iss_valid), 32'd1);
      tick();

      // 3: oldest-first select, stable under back-pressure
      bus.rob_head  = 4'd1;
      bus.iss_ready = 1'b0;
      disp(4'd6, 8'h36, 1'b0, 32'h60, 1'b0, 32'h61);
      tick();
      disp(4'd2, 8'h32, 1'b0, 32'h20, 1'b0, 32'h21);
      tick(); idle();
      @(negedge clk);
      check_val("t3_oldest_tag", 32'(bus.iss_tag), 32'd2);
      tick();
      @(negedge clk);
      check_val("t3_hold_valid", 32'(bus.iss_valid), 32'd1);
      check_val("t3_hold_tag",   32'(bus.iss_tag),   32'd2);
      check_val("t3_hold_src1",  bus.iss_src1,       32'h20);
      tick();
      push(4'd2, 8'h32, 32'h20, 32'h21);
      push(4'd6, 8'h36, 32'h60, 32'h61);
      drain("t3_drain");

      // 4: fill to full, issue+dispatch same cycle stalls the dispatch
      bus.rob_head  = 4'd0;
      bus.iss_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         disp(4'(k), 8'(8'h40 + k), 1'b0, 32'(100 + k), 1'b0, 32'(200 + k));
         @(negedge clk);
         check_val("t4_fill_ready", 32'(bus.disp_ready), 32'd1);
         tick();
      end
      disp(4'd8, 8'h48, 1'b0, 32'd108, 1'b0, 32'd208);
      bus.iss_ready = 1'b1;
      push(4'd0, 8'h40, 32'd100, 32'd200);
      @(negedge clk);
      check_val("t4_full_count", 32'(bus.count),      32'd8);
      check_val("t4_full_ready", 32'(bus.disp_ready), 32'd0);
      tick();
      bus.iss_ready = 1'b0;
      @(negedge clk);
      check_val("t4_count_7",    32'(bus.count),      32'd7);
      check_val("t4_ready_again", 32'(bus.disp_ready), 32'd1);
      tick(); idle();
      @(negedge clk);
      check_val("t4_count_8", 32'(bus.count), 32'd8);
      tick();
      for (int k = 1; k <= 8; k++) begin
         push(4'(k), 8'(8'h40 + k), 32'(100 + k), 32'(200 + k));
      end
      drain("t4_drain");
      @(negedge clk);
      check_val("t4_empty", 32'(bus.count), 32'd0);
      tick();

      // 5: age-based partial flush across ROB wrap
      bus.rob_head  = 4'd14;
      bus.iss_ready = 1'b0;
      disp(4'd14, 8'h5E, 1'b0, 32'hE0, 1'b0, 32'hE1); tick();
      disp(4'd15, 8'h5F, 1'b0, 32'hF0, 1'b0, 32'hF1); tick();
      disp(4'd0,  8'h50, 1'b0, 32'h00, 1'b0, 32'h01); tick();
      disp(4'd1,  8'h51, 1'b0, 32'h10, 1'b0, 32'h11); tick();
      disp(4'd2,  8'h52, 1'b0, 32'h20, 1'b0, 32'h21);
      bus.flush_valid = 1'b1;
      bus.flush_tag   = 4'd0;
      bus.iss_ready   = 1'b1;
      @(negedge clk);
      check_val("t5_no_issue_on_flush", 32'(bus.iss_valid), 32'd0);
      tick(); idle();
      bus.iss_ready = 1'b0;
      @(negedge clk);
      check_val("t5_count_after_flush", 32'(bus.count), 32'd2);
      tick();
      push(4'd14, 8'h5E, 32'hE0, 32'hE1);
      push(4'd15, 8'h5F, 32'hF0, 32'hF1);
      drain("t5_drain");

      // 6: dispatch forwarding from CDB channel 1
      bus.rob_head  = 4'd0;
      bus.iss_ready = 1'b1;
      disp(4'd7, 8'h67, 1'b0, 32'h1, 1'b1, 32'd5);
      cdb(0, 4'd9, 32'h11);
      cdb(1, 4'd5, 32'h42);
      push(4'd7, 8'h67, 32'h1, 32'h42);
      @(negedge clk);
      check_val("t6_no_issue_same_cycle", 32'(bus.iss_valid), 32'd0);
      tick(); idle();
      @(negedge clk);
      check_val("t6_iss_valid", 32'(bus.iss_valid), 32'd1);
      tick();

      // 7: two channels hit the same tag, lowest channel wins
      disp(4'd3, 8'h73, 1'b1, 32'd9, 1'b0, 32'd2);
      tick(); idle();
      cdb(0, 4'd9, 32'hA);
      cdb(1, 4'd9, 32'hB);
      push(4'd3, 8'h73, 32'hA, 32'd2);
      @(negedge clk);
      check_val("t7_not_ready_at_wakeup", 32'(bus.iss_valid), 32'd0);
      tick(); idle();
      @(negedge clk);
      check_val("t7_iss_valid", 32'(bus.iss_valid), 32'd1);
      tick();

      // 8: reset mid-operation blocks the issue and clears state
      bus.iss_ready = 1'b0;
      disp(4'd5, 8'h85, 1'b0, 32'h55, 1'b0, 32'h56);
      tick(); idle();
      @(negedge clk);
      check_val("t8_pending_valid", 32'(bus.iss_valid), 32'd1);
      tick();
      rst = 1'b1;
      bus.iss_ready = 1'b1;
      @(negedge clk);
      check_val("t8_no_issue_in_rst", 32'(bus.iss_valid), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_val("t8_count_cleared", 32'(bus.count),     32'd0);
      check_val("t8_valid_cleared", 32'(bus.iss_valid), 32'd0);
      tick();

      check_val("sb_leftover", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
